approx_sweep_ctrl: RTL and testbench

Sequencer and error-measurement controller for the board's exact/approximate multiplier pair. On a start pulse it sweeps every operand pair (A, B) over the full W-bit range through the shared multiplier datapath, one pair per cycle. It compares the exact and approximate products returned by the datapath and accumulates three error metrics: mismatch count, sum of absolute error, and maximum absolute error. It presents one metric, chosen by `sel`, on a 4W-bit result bus that drives the LEDs.

---
 rtl/approx_sweep_pkg.sv | 29 ++
 rtl/err_accum.sv | 49 ++++
 rtl/approx_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_approx_sweep_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_sweep_pkg.sv
// Shared definitions for the exact/approximate multiplier sweep controller:
// FSM states, result-select codes and width helpers derived from the operand width.
package approx_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_MISMATCH = 2'd0;
    localparam logic [1:0] SEL_SUM      = 2'd1;
    localparam logic [1:0] SEL_MAX      = 2'd2;
    localparam logic [1:0] SEL_STATUS   = 2'd3;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/err_accum.sv
// Absolute-error computation between exact and approximate products, feeding
// the mismatch counter, the error sum and the running maximum error.
module err_accum
    import approx_sweep_pkg::*;
#(
    parameter int W = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [2*W-1:0]   exact_p,
    input  logic [2*W-1:0]   approx_p,
    output logic [2*W:0]     mismatch_cnt,
    output logic [4*W-1:0]   err_sum,
    output logic [2*W-1:0]   max_err
);

    localparam int PW = prod_w(W);
    localparam int CW = cnt_w(W);
    localparam int SW = sum_w(W);

    logic [PW:0]   diff;
    logic [PW:0]   mag;
    logic [PW-1:0] err;

    // One extra bit keeps the difference signed; its magnitude always fits in PW bits.
    always_comb begin
        diff = {1'b0, exact_p} - {1'b0, approx_p};
        mag  = diff[PW] ? (~diff + 1'b1) : diff;
        err  = mag[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mismatch_cnt <= '0;
            err_sum      <= '0;
            max_err      <= '0;
        end else if (sample_en) begin
            mismatch_cnt <= mismatch_cnt + CW'(err != '0);
            err_sum      <= err_sum + SW'(err);
            if (err > max_err) begin
                max_err <= err;
            end
        end
    end

endmodule

// File: rtl/approx_sweep_ctrl.sv
// Sweeps every operand pair through the shared multiplier datapath, tracks the
// in-flight pairs across the datapath latency and reports one error metric.
module approx_sweep_ctrl
    import approx_sweep_pkg::*;
#(
    parameter int W   = 4,
    parameter int LAT = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sel,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic             op_valid,
    input  logic [2*W-1:0]   exact_p,
    input  logic [2*W-1:0]   approx_p,
    output logic             busy,
    output logic             done,
    output logic [4*W-1:0]   result
);

    localparam int IW = prod_w(W);
    localparam int SW = sum_w(W);
    localparam logic [IW-1:0] LAST_IDX = '1;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            pending;
    logic            sample_en;
    logic [LAT:0]    vpipe;
    logic [LAT:0]    vchain;
    logic [2*W:0]    mismatch_cnt;
    logic [4*W-1:0]  err_sum;
    logic [2*W-1:0]  max_err;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A combinational datapath has nothing left in flight after the last issue.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_ISSUE;
            S_ISSUE: if (idx == LAST_IDX) state_next = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (!pending) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_ISSUE;
            default: state_next = S_IDLE;
        endcase
    end

    // idx is the pair currently presented; it wraps to 0 after the final pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            op_valid <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            op_valid <= 1'b1;
        end else if (state == S_ISSUE) begin
            idx      <= idx + 1'b1;
            op_valid <= (idx != LAST_IDX);
        end
    end

    assign op_a = idx[IW-1:W];
    assign op_b = idx[W-1:0];

    // vchain[k] is op_valid delayed by k cycles; vchain[LAT] marks a returning product.
    always_comb begin
        vchain    = vpipe;
        vchain[0] = op_valid;
        sample_en = vchain[LAT];
        pending   = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            pending = pending | vchain[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= vchain << 1;
        end
    end

    err_accum #(.W(W)) u_err_accum (
        .clk          (clk),
        .rst          (rst),
        .clear        (accept),
        .sample_en    (sample_en),
        .exact_p      (exact_p),
        .approx_p     (approx_p),
        .mismatch_cnt (mismatch_cnt),
        .err_sum      (err_sum),
        .max_err      (max_err)
    );

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        result = '0;
        case (sel)
            SEL_MISMATCH: result = SW'(mismatch_cnt);
            SEL_SUM:      result = err_sum;
            SEL_MAX:      result = SW'(max_err);
            SEL_STATUS:   result = {done, busy, {(SW-2){1'b0}}};
            default:      result = '0;
        endcase
    end

endmodule

// File: tb/tb_approx_sweep_ctrl.sv
// Directed bench for approx_sweep_ctrl: three instances (LAT 1, 0, 4) share the
// stimulus, each driven by its own model datapath with a selectable approximation.
module tb_approx_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    int          mode = 0;

    int          errors = 0;
    int          checks = 0;
    int          done_cyc1, done_cyc0, done_cyc4;

    logic [3:0]  d1_op_a, d1_op_b, d0_op_a, d0_op_b, d4_op_a, d4_op_b;
    logic        d1_op_valid, d0_op_valid, d4_op_valid;
    logic [7:0]  d1_exact, d1_approx, d0_exact, d0_approx, d4_exact, d4_approx;
    logic        d1_busy, d1_done, d0_busy, d0_done, d4_busy, d4_done;
    logic [15:0] d1_result, d0_result, d4_result;

    logic [7:0]  p1;
    logic [7:0]  p4 [4];

    int          vcount = 0;
    int          order_err = 0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    approx_sweep_ctrl #(.W(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .op_a(d1_op_a), .op_b(d1_op_b), .op_valid(d1_op_valid),
        .exact_p(d1_exact), .approx_p(d1_approx),
        .busy(d1_busy), .done(d1_done), .result(d1_result)
    );

    approx_sweep_ctrl #(.W(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .op_a(d0_op_a), .op_b(d0_op_b), .op_valid(d0_op_valid),
        .exact_p(d0_exact), .approx_p(d0_approx),
        .busy(d0_busy), .done(d0_done), .result(d0_result)
    );

    approx_sweep_ctrl #(.W(4), .LAT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sel(sel),
        .op_a(d4_op_a), .op_b(d4_op_b), .op_valid(d4_op_valid),
        .exact_p(d4_exact), .approx_p(d4_approx),
        .busy(d4_busy), .done(d4_done), .result(d4_result)
    );

    function automatic logic [7:0] approx_fn(input int m, input logic [7:0] e);
        case (m)
            0:       return e;
            1:       return e & 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    // Model datapaths with the latency each instance expects.
    always @(posedge clk) begin
        p1    <= {d1_op_a, d1_op_b};
        p4[0] <= {d4_op_a, d4_op_b};
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    assign d1_exact  = 8'(p1[7:4] * p1[3:0]);
    assign d1_approx = approx_fn(mode, d1_exact);
    assign d0_exact  = 8'(d0_op_a * d0_op_b);
    assign d0_approx = approx_fn(mode, d0_exact);
    assign d4_exact  = 8'(p4[3][7:4] * p4[3][3:0]);
    assign d4_approx = approx_fn(mode, d4_exact);

    // Issue-order monitor on the LAT=1 instance; restarts on each rising op_valid.
    always @(negedge clk) begin
        if (d1_op_valid) begin
            if (!prev_valid) begin
                vcount    = 0;
                order_err = 0;
            end
            if ({d1_op_a, d1_op_b} !== vcount[7:0]) order_err++;
            vcount++;
        end
        prev_valid = d1_op_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        @(negedge clk);
        start = s;
        rst   = r;
    endtask

    task automatic checkIdle(input string tag);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checkOutput({tag, "_result_lat1"}, 32'(d1_result), 32'd0);
            checkOutput({tag, "_result_lat0"}, 32'(d0_result), 32'd0);
            checkOutput({tag, "_result_lat4"}, 32'(d4_result), 32'd0);
        end
        sel = 2'd0;
        checkOutput({tag, "_ctrl_lat1"}, 32'({d1_busy, d1_done, d1_op_valid, d1_op_a, d1_op_b}), 32'd0);
        checkOutput({tag, "_ctrl_lat0"}, 32'({d0_busy, d0_done, d0_op_valid, d0_op_a, d0_op_b}), 32'd0);
        checkOutput({tag, "_ctrl_lat4"}, 32'({d4_busy, d4_done, d4_op_valid, d4_op_a, d4_op_b}), 32'd0);
    endtask

    task automatic checkMetrics(input string tag, input int m, input int s, input int x);
        sel = 2'd0; #1;
        checkOutput({tag, "_mismatch_lat1"}, 32'(d1_result), m);
        checkOutput({tag, "_mismatch_lat0"}, 32'(d0_result), m);
        checkOutput({tag, "_mismatch_lat4"}, 32'(d4_result), m);
        sel = 2'd1; #1;
        checkOutput({tag, "_sum_lat1"}, 32'(d1_result), s);
        checkOutput({tag, "_sum_lat0"}, 32'(d0_result), s);
        checkOutput({tag, "_sum_lat4"}, 32'(d4_result), s);
        sel = 2'd2; #1;
        checkOutput({tag, "_max_lat1"}, 32'(d1_result), x);
        checkOutput({tag, "_max_lat0"}, 32'(d0_result), x);
        checkOutput({tag, "_max_lat4"}, 32'(d4_result), x);
        sel = 2'd3; #1;
        checkOutput({tag, "_status_lat1"}, 32'(d1_result), 32'h8000);
        sel = 2'd0;
    endtask

    // Pulses start, then watches each instance for done within a bounded window.
    task automatic runSweep(input string tag, input bit extra_starts, input int abort_at);
        int cyc;
        done_cyc1 = -1;
        done_cyc0 = -1;
        done_cyc4 = -1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        cyc = 1;
        while (cyc <= 400 && (done_cyc1 < 0 || done_cyc0 < 0 || done_cyc4 < 0)) begin
            if (cyc == 1) begin
                checkOutput({tag, "_busy_c1"}, 32'({d1_busy, d1_done}), 32'd2);
                checkOutput({tag, "_cleared_lat1"}, 32'(d1_result), 32'd0);
                checkOutput({tag, "_cleared_lat0"}, 32'(d0_result), 32'd0);
                checkOutput({tag, "_cleared_lat4"}, 32'(d4_result), 32'd0);
            end
            if (done_cyc1 < 0 && d1_done) begin
                done_cyc1 = cyc;
                checkOutput({tag, "_busy_fall_lat1"}, 32'(d1_busy), 32'd0);
            end
            if (done_cyc0 < 0 && d0_done) done_cyc0 = cyc;
            if (done_cyc4 < 0 && d4_done) done_cyc4 = cyc;
            if (abort_at != 0 && cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdle({tag, "_abort"});
                return;
            end
            start = (extra_starts && (cyc == 50 || cyc == 200)) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput({tag, "_done_cycle_lat1"}, 32'(done_cyc1), 32'd258);
        checkOutput({tag, "_done_cycle_lat0"}, 32'(done_cyc0), 32'd257);
        checkOutput({tag, "_done_cycle_lat4"}, 32'(done_cyc4), 32'd261);
        checkOutput({tag, "_valid_count"}, 32'(vcount), 32'd256);
        checkOutput({tag, "_issue_order"}, 32'(order_err), 32'd0);
    endtask

    initial begin
        // Reset held, then ten idle cycles with no start.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkIdle("reset_idle");

        // start coinciding with rst must be dropped.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkIdle("start_with_rst_a");
        @(negedge clk);
        checkIdle("start_with_rst_b");

        mode = 0;
        runSweep("exact", 1'b0, 0);
        checkMetrics("exact", 0, 0, 0);

        mode = 1;
        runSweep("lsb", 1'b0, 0);
        checkMetrics("lsb", 64, 64, 1);

        mode = 2;
        runSweep("zero_ign", 1'b1, 0);
        checkMetrics("zero_ign", 225, 14400, 225);

        runSweep("zero_again", 1'b0, 0);
        checkMetrics("zero_again", 225, 14400, 225);

        runSweep("abort", 1'b0, 100);
        @(negedge clk);
        checkIdle("abort_hold");

        runSweep("post_abort", 1'b0, 0);
        checkMetrics("post_abort", 225, 14400, 225);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
